uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NumRequesters, default 4, number of byte-stream requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter DataBits, default 8, character width matching the uart_tx DataBits; legal range 5..9.
REQ-003 Parameter IdleTimeout, default 1024, number of consecutive idle cycles after which a mid-packet grant is revoked; 0 disables the timeout.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_data  input  NumRequesters*DataBits  per-requester character; requester i occupies bits [i*DataBits +: DataBits].
REQ-007 req_valid  input  NumRequesters  per-requester character valid.
REQ-008 req_last  input  NumRequesters  per-requester flag marking the final character of a packet; qualified by req_valid.
REQ-009 req_ready  output  NumRequesters  per-requester accept strobe.
REQ-010 tx_data  output  DataBits  character to uart_tx data_in.
REQ-011 tx_valid  output  1  to uart_tx data_in_valid.
REQ-012 tx_ready  input  1  from uart_tx ready.
REQ-013 grant  output  NumRequesters  one-hot owner of the transmitter; all-zero when idle.
REQ-014 timeout  output  1  one-cycle pulse when a grant is revoked by the idle timeout.

Function
REQ-015 The state machine SHALL have exactly two states: IDLE (no owner) and LOCKED (one owner held in the grant register).
REQ-016 IDLE: if any req_valid bit is high, the next state SHALL be LOCKED, with the grant going to the first requester with valid high, searching round-robin from (last_owner+1) mod NumRequesters; otherwise IDLE is held.
REQ-017 Arbitration SHALL take exactly one cycle: grant is registered, and no character is transferred in the arbitration cycle.
REQ-018 In LOCKED: tx_valid = req_valid[owner]; tx_data = req_data slice of owner; req_ready[owner] = tx_ready; all other req_ready bits = 0 (combinational pass-through, no buffering).
REQ-019 In IDLE: tx_valid = 0, tx_data = 0, req_ready = 0.
REQ-020 A transfer SHALL occur on any cycle in which tx_valid and tx_ready are both high; exactly one character per transfer.
REQ-021 A transfer with req_last[owner] = 1 SHALL move the state to IDLE on the next edge, record owner as last_owner, and clear grant, leaving one bubble cycle before any re-grant.
REQ-022 A transfer with req_last = 0 SHALL keep LOCKED with the same owner; the packet is never interleaved with other requesters.
REQ-023 The idle counter SHALL clear on entry to LOCKED and on every transfer, and SHALL increment on each LOCKED cycle with req_valid[owner] = 0; cycles with valid high but tx_ready low SHALL NOT count.
REQ-024 When IdleTimeout > 0 and the counter reaches IdleTimeout, the next edge SHALL go to IDLE, set last_owner = owner, and pulse timeout for one cycle; the counter SHALL saturate and never wrap.
REQ-025 A transfer in the same cycle the counter would expire SHALL take precedence: the counter clears and no timeout fires.
REQ-026 Requesters other than the owner SHALL be ignored in LOCKED, regardless of their valid state.
REQ-027 Counter width SHALL be $clog2(IdleTimeout+1), with a minimum of 1 bit; the round-robin pointer width SHALL be $clog2(NumRequesters).

Reset
REQ-028 On rst assertion the block SHALL enter IDLE immediately, with grant = 0, tx_valid = 0, req_ready = 0, timeout = 0, idle counter = 0, and last_owner = NumRequesters-1, so requester 0 has first priority.
REQ-029 Reset mid-packet SHALL abandon the packet without emitting further characters; a partially sent uart_tx character is owned by uart_tx reset.

Verification
REQ-030 Scenario: after reset, req_valid = 4'b1010 -> grant = 4'b0010 one cycle later; 3-character packet from requester 1 is sent in order, then grant = 0 for one cycle.
REQ-031 Scenario: all four requesters continuously send 1-character packets -> grant sequence is 0,1,2,3,0 with one idle cycle between packets.
REQ-032 Scenario: requester 2 owns the grant mid-packet while requester 0 asserts valid -> req_ready[0] stays 0 until requester 2's last character is transferred.
REQ-033 Scenario: IdleTimeout = 8, owner drops valid after 1 character -> timeout pulses once, 8 idle cycles after the last transfer; grant then moves to the next valid requester.
REQ-034 Scenario: owner holds valid with tx_ready = 0 for 100 cycles (IdleTimeout = 8) -> no timeout, grant is held.
REQ-035 Scenario: rst pulsed while LOCKED -> tx_valid and grant drop to 0 asynchronously; the first post-reset grant goes to requester 0 if it is valid.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-stream requesters on one side, a shared uart_tx on the other.
interface uart_tx_arbiter_if #(
    parameter int NumRequesters = 4,
    parameter int DataBits = 8
);
    logic [NumRequesters*DataBits-1:0] req_data;
    logic [NumRequesters-1:0] req_valid;
    logic [NumRequesters-1:0] req_last;
    logic [NumRequesters-1:0] req_ready;
    logic [DataBits-1:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic [NumRequesters-1:0] grant;
    logic timeout;
    modport master (
        output req_data, req_valid, req_last, tx_ready,
        input req_ready, tx_data, tx_valid, grant, timeout
    );
    modport slave (
        input req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter feeding one uart_tx, with idle-timeout revoke.
module uart_tx_arbiter #(
    parameter int NumRequesters = 4,
    parameter int DataBits = 8,
    parameter int IdleTimeout = 1024
) (
    input logic clk,
    input logic rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int CW = $clog2(IdleTimeout + 1) > 1 ? $clog2(IdleTimeout + 1) : 1;
    localparam int PW = $clog2(NumRequesters);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state;
    logic [PW-1:0] owner, last_owner, pick;
    logic [CW-1:0] idle_cnt;
    logic [NumRequesters-1:0] rot;
    logic [DataBits-1:0] own_data;
    logic own_valid, own_last, xfer, expire;
    int off;
    // Rotate so bit 0 is the requester right after last_owner; the lowest set bit wins.
    always_comb begin
        rot = NumRequesters'({bus.req_valid, bus.req_valid} >> ((PW+1)'(last_owner) + (PW+1)'(1)));
        off = 0;
        for (int i = NumRequesters - 1; i >= 0; i--)
            if (rot[i]) off = i;
        pick = PW'((int'(last_owner) + 1 + off) % NumRequesters);
        own_valid = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int i = 0; i < NumRequesters; i++)
            if (owner == PW'(i)) begin
                own_valid = bus.req_valid[i];
                own_last = bus.req_last[i];
                own_data = bus.req_data[i*DataBits +: DataBits];
            end
    end
    assign xfer = state == LOCKED && own_valid && bus.tx_ready;
    assign expire = IdleTimeout > 0 && idle_cnt == CW'(IdleTimeout);
    assign bus.tx_valid = state == LOCKED && own_valid;
    assign bus.tx_data = state == LOCKED ? own_data : '0;
    assign bus.req_ready = state == LOCKED && bus.tx_ready ? bus.grant : '0;
    // A transfer outranks an expiring counter, so a late character still lands.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            last_owner <= PW'(NumRequesters - 1);
            idle_cnt <= '0;
            bus.grant <= '0;
            bus.timeout <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            if (state == IDLE) begin
                if (|bus.req_valid) begin
                    state <= LOCKED;
                    owner <= pick;
                    bus.grant <= NumRequesters'(1) << pick;
                    idle_cnt <= '0;
                end
            end else if (xfer) begin
                idle_cnt <= '0;
                if (own_last) begin
                    state <= IDLE;
                    last_owner <= owner;
                    bus.grant <= '0;
                end
            end else if (expire) begin
                state <= IDLE;
                last_owner <= owner;
                bus.grant <= '0;
                bus.timeout <= 1'b1;
                idle_cnt <= '0;
            end else if (!own_valid && idle_cnt != '1) begin
                idle_cnt <= idle_cnt + CW'(1);
            end
        end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and random traffic vs a reference model.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int D = 8;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    uart_tx_arbiter_if #(.NumRequesters(N), .DataBits(D)) bus();
    uart_tx_arbiter #(.NumRequesters(N), .DataBits(D), .IdleTimeout(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int checks = 0;
    int errors = 0;
    int m_own, m_last, m_idle;
    logic m_to;
    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic r;
        logic [31:0] d;
        logic [3:0] g;
        logic tv;
        logic [7:0] td;
        logic [3:0] rdy;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r, input logic [31:0] d);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_last = l;
        bus.tx_ready = r;
        bus.req_data = d;
        #2;
    endtask

    // Model: owner index or -1, packet lock, round-robin after last owner, idle-cycle timeout.
    task automatic model_check();
        logic [3:0] v, lst, eg, er;
        logic ev;
        logic [7:0] ed;
        int c;
        v = bus.req_valid;
        lst = bus.req_last;
        eg = 4'b0;
        er = 4'b0;
        ev = 1'b0;
        ed = 8'h0;
        if (m_own >= 0) begin
            eg = 4'(1 << m_own);
            ev = v[m_own[1:0]];
            ed = 8'(bus.req_data >> (m_own * D));
            er = bus.tx_ready ? eg : 4'b0;
        end
        chk("model_grant", 32'(bus.grant), 32'(eg));
        chk("model_tx_valid", 32'(bus.tx_valid), 32'(ev));
        chk("model_tx_data", 32'(bus.tx_data), 32'(ed));
        chk("model_req_ready", 32'(bus.req_ready), 32'(er));
        chk("model_timeout", 32'(bus.timeout), 32'(m_to));
        m_to = 1'b0;
        if (m_own < 0) begin
            if (v != 4'b0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (v[c[1:0]]) begin
                        m_own = c;
                        break;
                    end
                end
                m_idle = 0;
            end
        end else if (ev && bus.tx_ready) begin
            m_idle = 0;
            if (lst[m_own[1:0]]) begin
                m_last = m_own;
                m_own = -1;
            end
        end else if (m_idle >= TO) begin
            m_last = m_own;
            m_own = -1;
            m_to = 1'b1;
            m_idle = 0;
        end else if (!ev) begin
            m_idle++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        bus.req_valid = 4'b0;
        bus.req_last = 4'b0;
        bus.tx_ready = 1'b0;
        bus.req_data = 32'b0;
        @(negedge clk);
        rst = 1'b0;
        m_own = -1;
        m_last = N - 1;
        m_idle = 0;
        m_to = 1'b0;
    endtask

    initial begin
        logic [3:0] q31[$];
        logic [3:0] want31[5];
        logic [3:0] v, l;
        int pulses, tcyc;
        logic seen;
        tbl[0] = '{4'b1010, 4'b0000, 1'b1, 32'h0000_A100, 4'b0000, 1'b0, 8'h00, 4'b0000};
        tbl[1] = '{4'b1010, 4'b0000, 1'b1, 32'h0000_A100, 4'b0010, 1'b1, 8'hA1, 4'b0010};
        tbl[2] = '{4'b1010, 4'b0000, 1'b1, 32'h0000_A200, 4'b0010, 1'b1, 8'hA2, 4'b0010};
        tbl[3] = '{4'b1010, 4'b0010, 1'b1, 32'h0000_A300, 4'b0010, 1'b1, 8'hA3, 4'b0010};
        tbl[4] = '{4'b1010, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 4'b0000};
        tbl[5] = '{4'b1000, 4'b1000, 1'b0, 32'hB100_0000, 4'b1000, 1'b1, 8'hB1, 4'b0000};
        tbl[6] = '{4'b1000, 4'b1000, 1'b1, 32'hB100_0000, 4'b1000, 1'b1, 8'hB1, 4'b1000};
        tbl[7] = '{4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 4'b0000};
        want31 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.req_valid = 4'b0;
        bus.req_last = 4'b0;
        bus.tx_ready = 1'b0;
        bus.req_data = 32'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].d);
            chk("tbl_grant", 32'(bus.grant), 32'(tbl[i].g));
            chk("tbl_tx_valid", 32'(bus.tx_valid), 32'(tbl[i].tv));
            chk("tbl_tx_data", 32'(bus.tx_data), 32'(tbl[i].td));
            chk("tbl_req_ready", 32'(bus.req_ready), 32'(tbl[i].rdy));
            model_check();
        end
        // All requesters stream single-character packets.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(4'hF, 4'hF, 1'b1, $urandom);
            if (bus.tx_valid && bus.tx_ready) q31.push_back(bus.grant);
            model_check();
        end
        chk("rr_count", 32'(q31.size()), 5);
        for (int i = 0; i < 5 && i < q31.size(); i++) chk("rr_order", 32'(q31[i]), 32'(want31[i]));
        // Requester 0 waits while requester 2 finishes its packet.
        do_reset();
        drive(4'b0100, 4'b0000, 1'b1, $urandom);
        model_check();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0101, i == 3 ? 4'b0100 : 4'b0000, 1'b1, $urandom);
            chk("lock_ready0", 32'(bus.req_ready[0]), 0);
            chk("lock_ready2", 32'(bus.req_ready[2]), 1);
            model_check();
        end
        drive(4'b0001, 4'b0000, 1'b1, $urandom);
        chk("lock_bubble", 32'(bus.grant), 0);
        model_check();
        drive(4'b0001, 4'b0000, 1'b1, $urandom);
        chk("lock_next", 32'(bus.req_ready), 32'(4'b0001));
        model_check();
        // Owner goes quiet after one character.
        do_reset();
        pulses = 0;
        tcyc = -1;
        for (int c = 0; c < 16; c++) begin
            v = c <= 1 ? 4'b0001 : (c >= 11 ? 4'b0010 : 4'b0000);
            l = c >= 11 ? 4'b0010 : 4'b0000;
            drive(v, l, 1'b1, $urandom);
            if (bus.timeout) begin
                pulses++;
                tcyc = c;
            end
            if (c == 12) chk("to_regrant", 32'(bus.grant), 32'(4'b0010));
            model_check();
        end
        chk("to_pulses", 32'(pulses), 1);
        chk("to_cycle", 32'(tcyc), 11);
        // Stalled uart_tx never counts as idle.
        do_reset();
        seen = 1'b0;
        for (int c = 0; c < 101; c++) begin
            drive(4'b0001, 4'b0001, 1'b0, 32'h5A);
            seen |= bus.timeout;
            model_check();
        end
        chk("stall_no_timeout", 32'(seen), 0);
        chk("stall_grant", 32'(bus.grant), 32'(4'b0001));
        drive(4'b0001, 4'b0001, 1'b1, 32'h5A);
        chk("stall_release", 32'(bus.req_ready), 32'(4'b0001));
        model_check();
        // Reset in the middle of a packet.
        do_reset();
        drive(4'b0100, 4'b0000, 1'b1, $urandom);
        model_check();
        drive(4'b0100, 4'b0000, 1'b1, $urandom);
        chk("mid_rst_pre_valid", 32'(bus.tx_valid), 1);
        model_check();
        do_reset();
        drive(4'b0101, 4'b0000, 1'b1, $urandom);
        chk("post_rst_idle", 32'(bus.grant), 0);
        model_check();
        drive(4'b0101, 4'b0000, 1'b1, $urandom);
        chk("post_rst_grant", 32'(bus.grant), 32'(4'b0001));
        model_check();
        // Random traffic with periodic quiet windows to exercise the timeout.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = (i % 60) >= 45 ? 4'b0000 : 4'($urandom);
            l = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0000;
            drive(v, l, ($urandom % 4) != 0, $urandom);
            model_check();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
